operand_entry: RTL and testbench



---
 rtl/operand_entry_pkg.sv | 16 +
 rtl/btn_debounce.sv | 63 ++++++
 rtl/operand_entry.sv | 127 ++++++++++++
 tb/tb_operand_entry.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/operand_entry_pkg.sv
// Shared definitions for the operand entry front end: entry stage encoding
// and default debounce timing for a 100 MHz board clock.
package operand_entry_pkg;

    typedef enum logic [1:0] {
        S_A    = 2'd0,
        S_B    = 2'd1,
        S_OP   = 2'd2,
        S_SHOW = 2'd3
    } stage_t;

    // 10 ms of stable button level at 100 MHz
    localparam int DEFAULT_DEBOUNCE_CYCLES = 1000000;
    localparam int DEFAULT_CNT_W           = 20;

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: two-flop synchronizer, stability counter that flips the
// debounced level after DEBOUNCE_CYCLES consecutive disagreeing samples, and a
// single-cycle pulse on each rising edge of the debounced level.
module btn_debounce
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic level,
    output logic pulse
);

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1;
    logic             sync2;
    logic             level_q;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous button into the clock domain
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= btn_raw;
            sync2 <= sync1;
        end
    end

    // Count disagreeing samples; the Nth in a row flips the debounced level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level <= 1'b0;
            cnt   <= '0;
        end else if (sync2 != level) begin
            if (cnt == LAST_COUNT) begin
                level <= ~level;
                cnt   <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end else begin
            cnt <= '0;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/operand_entry.sv
// Operand entry stage: the user keys A, B, then opcode plus carry-in on one
// shared switch bank, committing each with NEXT; CLEAR restarts the sequence.
// Registered outputs feed the calculator top level directly.
module operand_entry
    import operand_entry_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter int CNT_W           = DEFAULT_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw,
    input  logic       sw_cin,
    input  logic       btn_next,
    input  logic       btn_clear,
    output logic [3:0] a,
    output logic [3:0] b,
    output logic [3:0] mode_d,
    output logic       c_in,
    output logic [1:0] stage,
    output logic       ready
);

    logic next_p;
    logic clear_p;
    logic unused_next_level;
    logic unused_clear_level;

    stage_t     state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] b_q, b_d;
    logic [3:0] mode_q, mode_d_nx;
    logic       cin_q, cin_d;
    logic       ready_q, ready_d;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_next_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_next),
        .level  (unused_next_level),
        .pulse  (next_p)
    );

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_clear_debounce (
        .clk    (clk),
        .rst    (rst),
        .btn_raw(btn_clear),
        .level  (unused_clear_level),
        .pulse  (clear_p)
    );

    // State and capture registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_A;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= '0;
            cin_q   <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d_nx;
            cin_q   <= cin_d;
            ready_q <= ready_d;
        end
    end

    // Entry sequencing: clear wins over next; otherwise next commits the
    // switch bank into the slot for the current stage and advances
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        mode_d_nx = mode_q;
        cin_d     = cin_q;
        ready_d   = ready_q;
        if (clear_p) begin
            state_d   = S_A;
            a_d       = '0;
            b_d       = '0;
            mode_d_nx = '0;
            cin_d     = 1'b0;
            ready_d   = 1'b0;
        end else if (next_p) begin
            case (state_q)
                S_A: begin
                    a_d     = sw;
                    state_d = S_B;
                end
                S_B: begin
                    b_d     = sw;
                    state_d = S_OP;
                end
                S_OP: begin
                    mode_d_nx = sw;
                    cin_d     = sw_cin;
                    ready_d   = 1'b1;
                    state_d   = S_SHOW;
                end
                S_SHOW: begin
                    ready_d = 1'b0;
                    state_d = S_A;
                end
                default: begin
                    state_d = S_A;
                end
            endcase
        end
    end

    assign a      = a_q;
    assign b      = b_q;
    assign mode_d = mode_q;
    assign c_in   = cin_q;
    assign stage  = state_q;
    assign ready  = ready_q;

endmodule

// File: tb/tb_operand_entry.sv
// Self-checking bench for operand_entry with a short debounce window.
// A behavioural model tracks raw button history and the entry sequence.
module tb_operand_entry;

    localparam int D = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] sw = 4'd0;
    logic       sw_cin = 1'b0;
    logic       btn_next = 1'b0;
    logic       btn_clear = 1'b0;
    logic [3:0] a, b, mode_d;
    logic       c_in, ready;
    logic [1:0] stage;

    int checks = 0;
    int errors = 0;

    operand_entry #(.DEBOUNCE_CYCLES(D), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .sw(sw), .sw_cin(sw_cin),
        .btn_next(btn_next), .btn_clear(btn_clear),
        .a(a), .b(b), .mode_d(mode_d), .c_in(c_in),
        .stage(stage), .ready(ready)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference model ----------------
    logic [3:0] m_a, m_b, m_op;
    bit         m_cin, m_ready;
    int         m_stage;
    bit         raw_n[$], raw_c[$];
    bit         hist_n[$], hist_c[$];
    bit         lvl_n, lvl_c, pend_n, pend_c;

    function automatic void model_reset();
        m_a = 0; m_b = 0; m_op = 0; m_cin = 0; m_ready = 0; m_stage = 0;
        raw_n = '{0, 0};
        raw_c = '{0, 0};
        hist_n.delete();
        hist_c.delete();
        lvl_n = 0; lvl_c = 0; pend_n = 0; pend_c = 0;
    endfunction

    // Debounced level changes once the last D synchronized samples all disagree with it
    function automatic void deb_model(input bit s, inout bit lvl, inout bit hist[$], output bit rose);
        bit all_diff;
        rose = 0;
        hist.push_back(s);
        if (hist.size() > D) void'(hist.pop_front());
        if (hist.size() == D) begin
            all_diff = 1;
            foreach (hist[i]) if (hist[i] == lvl) all_diff = 0;
            if (all_diff) begin
                rose = !lvl;
                lvl = !lvl;
                hist.delete();
            end
        end
    endfunction

    function automatic void model_step();
        bit s;
        if (rst) begin
            model_reset();
            return;
        end
        if (pend_c) begin
            m_stage = 0; m_a = 0; m_b = 0; m_op = 0; m_cin = 0; m_ready = 0;
        end else if (pend_n) begin
            case (m_stage)
                0: m_a = sw;
                1: m_b = sw;
                2: begin m_op = sw; m_cin = sw_cin; m_ready = 1; end
                default: m_ready = 0;
            endcase
            m_stage = (m_stage + 1) % 4;
        end
        raw_n.push_back(btn_next);
        s = raw_n.pop_front();
        deb_model(s, lvl_n, hist_n, pend_n);
        raw_c.push_back(btn_clear);
        s = raw_c.pop_front();
        deb_model(s, lvl_c, hist_c, pend_c);
    endfunction

    function automatic logic [15:0] model_vec();
        logic [1:0] st;
        st = 2'(m_stage);
        return {m_a, m_b, m_op, m_cin, st, m_ready};
    endfunction

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        btn_next = 0; btn_clear = 0;
        rst = 1;
        #1;
        model_reset();
        checks++;
        if ({a, b, mode_d, c_in, stage, ready} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_state: got %h expected %h", {a, b, mode_d, c_in, stage, ready}, 16'h0);
        end
        for (int i = 0; i < 20; i++) begin
            tick();
            checks++;
            if ({a, b, mode_d, c_in, stage, ready} !== 16'h0) begin
                errors++;
                $display("[TB] FAIL reset_hold cycle %0d: got %h expected %h", i, {a, b, mode_d, c_in, stage, ready}, 16'h0);
            end
        end
        rst = 0;
        idle(3);
    endtask

    task automatic test_bounce();
        btn_next = 1;
        idle(3);
        btn_next = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if ({a, b, mode_d, c_in, stage, ready} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL bounce cycle %0d: got %h expected %h", i, {a, b, mode_d, c_in, stage, ready}, model_vec());
            end
        end
        checks++;
        if (stage !== 2'd0 || a !== 4'd0) begin
            errors++;
            $display("[TB] FAIL bounce_no_advance: got stage %0d a %0d expected stage 0 a 0", stage, a);
        end
    endtask

    task automatic test_sequence();
        logic [3:0] va, vb, vop;
        logic       vc;
        int         n;
        va = 4'($urandom_range(15, 0));
        vb = 4'($urandom_range(15, 0));
        vop = 4'($urandom_range(15, 0));
        vc = 1'($urandom_range(1, 0));
        for (int k = 0; k < 3; k++) begin
            sw = (k == 0) ? va : (k == 1) ? vb : vop;
            sw_cin = (k == 2) ? vc : ~vc;
            btn_next = 1;
            n = 0;
            while (stage === 2'(k) && n < 20) begin
                tick();
                n++;
            end
            checks++;
            if (n !== 7) begin
                errors++;
                $display("[TB] FAIL capture_latency step %0d: got %0d cycles expected 7", k, n);
            end
            idle(10 - n);
            btn_next = 0;
            idle(10);
            checks++;
            if ({a, b, mode_d, c_in, stage, ready} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL sequence step %0d: got %h expected %h", k, {a, b, mode_d, c_in, stage, ready}, model_vec());
            end
        end
        checks++;
        if ({a, b, mode_d, c_in, stage, ready} !== {va, vb, vop, vc, 2'd3, 1'b1}) begin
            errors++;
            $display("[TB] FAIL sequence_final: got %h expected %h", {a, b, mode_d, c_in, stage, ready}, {va, vb, vop, vc, 2'd3, 1'b1});
        end
    endtask

    task automatic test_hold();
        rst = 1; #1; model_reset();
        tick();
        rst = 0;
        sw = 4'd9;
        btn_next = 1;
        for (int i = 0; i < 100; i++) begin
            tick();
            checks++;
            if ({a, b, mode_d, c_in, stage, ready} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL hold cycle %0d: got %h expected %h", i, {a, b, mode_d, c_in, stage, ready}, model_vec());
            end
        end
        checks++;
        if (a !== 4'd9 || stage !== 2'd1) begin
            errors++;
            $display("[TB] FAIL hold_single_advance: got a %0d stage %0d expected a 9 stage 1", a, stage);
        end
        btn_next = 0;
        idle(10);
    endtask

    task automatic test_clear_priority();
        sw = 4'($urandom_range(15, 0));
        btn_next = 1;
        btn_clear = 1;
        idle(10);
        btn_next = 0;
        btn_clear = 0;
        idle(10);
        checks++;
        if ({a, b, stage, ready} !== {4'd0, 4'd0, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL clear_priority: got a %0d b %0d stage %0d ready %0d expected all 0", a, b, stage, ready);
        end
        checks++;
        if ({a, b, mode_d, c_in, stage, ready} !== model_vec()) begin
            errors++;
            $display("[TB] FAIL clear_model: got %h expected %h", {a, b, mode_d, c_in, stage, ready}, model_vec());
        end
    endtask

    task automatic test_reset_mid_debounce();
        logic [3:0] va, vb, vop;
        int         n;
        // get outputs non-zero first so reset has something to clear
        va = 4'($urandom_range(15, 1));
        sw = va;
        btn_next = 1; idle(10); btn_next = 0; idle(10);
        btn_next = 1;
        idle(2);
        rst = 1;
        #1;
        model_reset();
        checks++;
        if ({a, b, mode_d, c_in, stage, ready} !== 16'h0) begin
            errors++;
            $display("[TB] FAIL reset_async: got %h expected %h", {a, b, mode_d, c_in, stage, ready}, 16'h0);
        end
        tick();
        rst = 0;
        n = 0;
        while (stage === 2'd0 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (n !== 7 || a !== va) begin
            errors++;
            $display("[TB] FAIL reset_held_press: got %0d cycles a %0d expected 7 cycles a %0d", n, a, va);
        end
        idle(50);
        checks++;
        if (stage !== 2'd1) begin
            errors++;
            $display("[TB] FAIL reset_single_pulse: got stage %0d expected 1", stage);
        end
        btn_next = 0; idle(10);
        vb = 4'($urandom_range(15, 0));
        sw = vb; btn_next = 1; idle(10); btn_next = 0; idle(10);
        vop = 4'($urandom_range(15, 0));
        sw = vop; sw_cin = 1; btn_next = 1; idle(10); btn_next = 0; idle(10);
        sw = 4'd0; sw_cin = 0; btn_next = 1; idle(10); btn_next = 0; idle(10);
        checks++;
        if ({a, b, mode_d, c_in, stage, ready} !== {va, vb, vop, 1'b1, 2'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL show_exit_retain: got %h expected %h", {a, b, mode_d, c_in, stage, ready}, {va, vb, vop, 1'b1, 2'd0, 1'b0});
        end
    endtask

    task automatic test_random();
        int run_n = 0, run_c = 0;
        for (int i = 0; i < 800; i++) begin
            if (run_n == 0) begin
                btn_next = 1'($urandom_range(1, 0));
                run_n = $urandom_range(12, 1);
            end
            if (run_c == 0) begin
                btn_clear = ($urandom_range(9, 0) == 0);
                run_c = $urandom_range(12, 1);
            end
            run_n--; run_c--;
            sw = 4'($urandom_range(15, 0));
            sw_cin = 1'($urandom_range(1, 0));
            tick();
            checks++;
            if ({a, b, mode_d, c_in, stage, ready} !== model_vec()) begin
                errors++;
                $display("[TB] FAIL random cycle %0d: got %h expected %h", i, {a, b, mode_d, c_in, stage, ready}, model_vec());
            end
            checks++;
            if (ready === 1'b1 && stage !== 2'd3) begin
                errors++;
                $display("[TB] FAIL ready_only_show cycle %0d: got stage %0d expected 3", i, stage);
            end
        end
        btn_next = 0; btn_clear = 0;
        idle(10);
    endtask

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        model_reset();
        @(negedge clk);
        test_reset();
        test_bounce();
        test_sequence();
        test_hold();
        test_clear_priority();
        test_reset_mid_debounce();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
